// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: FSM states, transfer op and the
// word returned when a handshake read is abandoned.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RD,
    S_DELIVER
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

  localparam logic [15:0] DEAD_WORD = 16'hDEAD;

endpackage

// File: rtl/rr_pick2.sv
// Two-way selector: fixed CPU priority with a one-shot fairness override for
// port 1, or plain round-robin. Holds last_denied across arbitrations.
module rr_pick2 #(
  parameter int CPU_PRIO = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       take_i,
  output logic       winner_o,
  output logic       valid_o
);

  logic last_denied_q;
  logic last_denied_d;

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    valid_o       = |req_i;
    winner_o      = 1'b0;
    last_denied_d = last_denied_q;
    if (req_i == 2'b10) begin
      winner_o = 1'b1;
    end else if (req_i == 2'b11) begin
      winner_o = (CPU_PRIO != 0) ? last_denied_q : ~last_grant_i;
    end
    if (take_i) begin
      last_denied_d = (req_i == 2'b11) && !winner_o;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_denied_q <= 1'b0;
    end else begin
      last_denied_q <= last_denied_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between the CPU (port 0) and a DMA/loader (port 1);
// sequences each transfer as ISSUE, then optional WAIT_RD/DELIVER for reads.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1,
  parameter int TIMEOUT    = 255,
  parameter int CPU_PRIO   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_wr_data_i,
  input  logic              r0_wr_en_i,
  input  logic              r0_rd_en_i,
  output logic              r0_busy_o,
  output logic [DATA_W-1:0] r0_rd_data_o,
  output logic              r0_rd_ready_o,
  input  logic              r0_rd_ack_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_wr_data_i,
  input  logic              r1_wr_en_i,
  input  logic              r1_rd_en_i,
  output logic              r1_busy_o,
  output logic [DATA_W-1:0] r1_rd_data_o,
  output logic              r1_rd_ready_o,
  input  logic              r1_rd_ack_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  output logic              mem_wr_en_o,
  output logic              mem_rd_en_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  input  logic              mem_busy_i,
  input  logic              mem_rd_ready_i,
  output logic              mem_rd_ack_o,
  output logic              grant_id_o,
  output logic              err_timeout_o
);

  // The counter serves both modes, so RD_LATENCY must not exceed TIMEOUT+1.
  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LATENCY - 1);

  state_e              state_q, state_d;
  op_e                 op_q;
  logic                grant_id_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wr_data_q;
  logic                mem_wr_en_q, mem_rd_en_q, mem_rd_ack_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rd_data0_q, rd_data1_q;
  logic [1:0]          rd_ready_q;
  logic                err_q;

  logic [1:0]          req;
  logic                winner, valid, take, win_wr;
  logic                rd_done, ack_d, timeout;
  logic [DATA_W-1:0]   rd_word;

  assign req    = {r1_wr_en_i | r1_rd_en_i, r0_wr_en_i | r0_rd_en_i};
  assign take   = (state_q == S_IDLE) && !mem_busy_i && valid;
  assign win_wr = winner ? r1_wr_en_i : r0_wr_en_i;

  rr_pick2 #(.CPU_PRIO(CPU_PRIO)) u_pick (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .last_grant_i (grant_id_q),
    .take_i       (take),
    .winner_o     (winner),
    .valid_o      (valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_done = 1'b0;
    ack_d   = 1'b0;
    timeout = 1'b0;
    rd_word = mem_rd_data_i;
    case (state_q)
      S_IDLE:   if (take) state_d = S_ISSUE;
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = (op_q == OP_WR) ? S_IDLE : S_WAIT_RD;
      end
      S_WAIT_RD: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (RD_LATENCY > 0) begin
          rd_done = (cnt_q == LAT_LAST);
        end else if (mem_rd_ready_i) begin
          rd_done = 1'b1;
          ack_d   = 1'b1;
        end else if (cnt_d == CNT_MAX) begin
          rd_done = 1'b1;
          timeout = 1'b1;
          rd_word = DATA_W'(DEAD_WORD);
        end
        if (rd_done) state_d = S_DELIVER;
      end
      S_DELIVER: if (grant_id_q ? r1_rd_ack_i : r0_rd_ack_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= OP_RD;
      grant_id_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_ack_q  <= 1'b0;
      cnt_q         <= '0;
      rd_data0_q    <= '0;
      rd_data1_q    <= '0;
      rd_ready_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_wr_en_q  <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      mem_rd_ack_q <= ack_d;
      // Capturing at grant time makes the strobes land exactly in ISSUE.
      if (take) begin
        grant_id_q    <= winner;
        op_q          <= win_wr ? OP_WR : OP_RD;
        mem_addr_q    <= winner ? r1_addr_i : r0_addr_i;
        mem_wr_data_q <= winner ? r1_wr_data_i : r0_wr_data_i;
        mem_wr_en_q   <= win_wr;
        mem_rd_en_q   <= !win_wr;
      end
      if (rd_done) begin
        if (grant_id_q) rd_data1_q <= rd_word;
        else            rd_data0_q <= rd_word;
        rd_ready_q[grant_id_q] <= 1'b1;
      end
      if (state_q == S_DELIVER && state_d == S_IDLE) rd_ready_q <= '0;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign r0_busy_o     = !(take && !winner);
  assign r1_busy_o     = !(take && winner);
  assign r0_rd_data_o  = rd_data0_q;
  assign r1_rd_data_o  = rd_data1_q;
  assign r0_rd_ready_o = rd_ready_q[0];
  assign r1_rd_ready_o = rd_ready_q[1];
  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_data_o = mem_wr_data_q;
  assign mem_wr_en_o   = mem_wr_en_q;
  assign mem_rd_en_o   = mem_rd_en_q;
  assign mem_rd_ack_o  = mem_rd_ack_q;
  assign grant_id_o    = grant_id_q;
  assign err_timeout_o = err_q;

endmodule
